// File: rtl/sel_sched_pkg.sv
// Shared sizing constants and lane-slicing helper for the lane-change scheduler.
package sel_sched_pkg;

    localparam int unsigned LANES  = 8;
    localparam int unsigned LANE_W = 3;
    localparam int unsigned SEL_W  = $clog2(LANES);
    localparam int unsigned WORD_W = LANES * LANE_W;

    function automatic logic [LANE_W-1:0] lane_slice(input logic [WORD_W-1:0] word,
                                                     input int idx);
        return word[idx*LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Stateless round-robin picker: first set request strictly after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned LANES = 8,
    parameter int unsigned SEL_W = $clog2(LANES)
) (
    input  logic [LANES-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        // k = LANES visits ptr itself last, so the previous winner has lowest priority.
        for (int unsigned k = 1; k <= LANES; k++) begin
            cand = SEL_W'((32'(ptr) + k) % LANES);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/sel_scheduler.sv
// Lane-change scheduler: detects per-lane changes of A and serialises them round-robin.
// Optional overwrite counter enabled by defining SEL_SCHED_DROP_CNT_EN.
module sel_scheduler #(
    parameter int unsigned LANES  = sel_sched_pkg::LANES,
    parameter int unsigned LANE_W = sel_sched_pkg::LANE_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES*LANE_W-1:0]   A,
    input  logic                      ready,
    output logic                      valid,
    output logic [$clog2(LANES)-1:0]  sel,
    output logic [LANE_W-1:0]         data
`ifdef SEL_SCHED_DROP_CNT_EN
    ,
    output logic [7:0]                drop_cnt
`endif
);

    import sel_sched_pkg::*;

    localparam int unsigned SW = $clog2(LANES);

    logic [LANES*LANE_W-1:0] a_prev_q;
    logic                    prev_vld_q;
    logic [LANES-1:0]        change;
    logic [LANES-1:0]        clear;
    logic [LANES-1:0]        pending_q, pending_d;
    logic [LANE_W-1:0]       hold_q [LANES];
    logic [LANE_W-1:0]       hold_d [LANES];
    logic [SW-1:0]           ptr_q;
    logic                    valid_q;
    logic [SW-1:0]           sel_q;
    logic [LANE_W-1:0]       data_q;
    logic [SW-1:0]           grant_idx;
    logic                    grant_valid;
    logic                    load_en;
    logic                    take;

    // prev_vld_q masks the first cycle after reset, when a_prev_q is not yet meaningful.
    always_comb begin
        change = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            change[i] = prev_vld_q && (lane_slice(A, i) != lane_slice(a_prev_q, i));
        end
    end

    rr_arbiter #(
        .LANES (LANES),
        .SEL_W (SW)
    ) u_arb (
        .req         (pending_q),
        .ptr         (ptr_q),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign load_en = !valid_q || ready;
    assign take    = load_en && grant_valid;

    // A change on the lane being granted re-arms it: set wins over clear.
    always_comb begin
        clear     = '0;
        pending_d = pending_q;
        hold_d    = hold_q;
        for (int i = 0; i < int'(LANES); i++) begin
            clear[i]     = take && (int'(grant_idx) == i);
            pending_d[i] = (pending_q[i] && !clear[i]) || change[i];
            if (change[i]) begin
                hold_d[i] = lane_slice(A, i);
            end
        end
    end

    always_ff @(posedge clk) begin
        a_prev_q <= A;
        if (rst) begin
            prev_vld_q <= 1'b0;
            pending_q  <= '0;
            for (int i = 0; i < int'(LANES); i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            prev_vld_q <= 1'b1;
            pending_q  <= pending_d;
            hold_q     <= hold_d;
        end
    end

    // Output register only advances when empty or the current item is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            sel_q   <= '0;
            data_q  <= '0;
            ptr_q   <= SW'(LANES - 1);
        end else if (load_en) begin
            valid_q <= grant_valid;
            if (grant_valid) begin
                sel_q  <= grant_idx;
                data_q <= hold_q[grant_idx];
                ptr_q  <= grant_idx;
            end
        end
    end

    assign valid = valid_q;
    assign sel   = sel_q;
    assign data  = data_q;

`ifdef SEL_SCHED_DROP_CNT_EN
    logic [7:0] drop_q;
    logic       overwrite;

    assign overwrite = |(change & pending_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= 8'd0;
        end else if (overwrite && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_sel_scheduler.sv
// Self-checking bench for sel_scheduler: directed scenarios plus random traffic vs a model.
module tb_sel_scheduler;

    logic        clk;
    logic        rst;
    logic [23:0] A;
    logic        ready;
    logic        valid;
    logic [2:0]  sel;
    logic [2:0]  data;
`ifdef SEL_SCHED_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    int errors = 0;
    int checks = 0;

    sel_scheduler dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .ready (ready),
        .valid (valid),
        .sel   (sel),
        .data  (data)
`ifdef SEL_SCHED_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    bit          m_pend [8];
    int          m_hold [8];
    int          m_last;
    bit          m_first;
    logic [23:0] m_prev;
    bit          m_valid;
    int          m_sel;
    int          m_data;
    int          m_drop;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lane_of(input logic [23:0] w, input int i);
        return int'((w >> (3 * i)) & 24'h7);
    endfunction

    task automatic model_step();
        bit chg [8];
        bit oldp [8];
        bit found;
        bit ovw;
        int j;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_pend[i] = 0;
                m_hold[i] = 0;
            end
            m_last = 7; m_first = 1; m_prev = A;
            m_valid = 0; m_sel = 0; m_data = 0; m_drop = 0;
            return;
        end
        ovw = 0;
        for (int i = 0; i < 8; i++) begin
            oldp[i] = m_pend[i];
            chg[i]  = !m_first && (lane_of(A, i) != lane_of(m_prev, i));
        end
        if (!m_valid || ready) begin
            found = 0;
            for (int k = 1; k <= 8; k++) begin
                j = (m_last + k) % 8;
                if (!found && oldp[j]) begin
                    found = 1; m_sel = j; m_data = m_hold[j]; m_last = j; m_pend[j] = 0;
                end
            end
            m_valid = found;
        end
        for (int i = 0; i < 8; i++) begin
            if (chg[i]) begin
                if (oldp[i]) ovw = 1;
                m_pend[i] = 1;
                m_hold[i] = lane_of(A, i);
            end
        end
        if (ovw && m_drop < 255) m_drop++;
        m_prev = A;
        m_first = 0;
    endtask

    task automatic compare_all();
        check_eq("model_valid", 32'(valid), 32'(m_valid));
        if (m_valid) begin
            check_eq("model_sel", 32'(sel), 32'(m_sel));
            check_eq("model_data", 32'(data), 32'(m_data));
        end
`ifdef SEL_SCHED_DROP_CNT_EN
        check_eq("model_drop", 32'(drop_cnt), 32'(m_drop));
`endif
    endtask

    // Drive inputs away from the edge, let one rising edge happen, sample on the falling edge.
    task automatic step(input logic r, input logic [23:0] a, input logic rd);
        rst = r; A = a; ready = rd;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [23:0] a;
        rst = 1'b1; A = '0; ready = 1'b0;
        @(negedge clk);

        // Reset state, then constant input produces nothing
        step(1'b1, 24'h0, 1'b0);
        step(1'b1, 24'h0, 1'b0);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_sel", 32'(sel), 32'd0);
        check_eq("rst_data", 32'(data), 32'd0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 24'h0, 1'b1);
            check_eq("idle_valid", 32'(valid), 32'd0);
        end

        // Single lane change: two-edge latency, one-cycle pulse
        step(1'b0, 24'h000005, 1'b1);
        check_eq("lat1_valid", 32'(valid), 32'd0);
        step(1'b0, 24'h000005, 1'b1);
        check_eq("lat2_valid", 32'(valid), 32'd1);
        check_eq("lat2_sel", 32'(sel), 32'd0);
        check_eq("lat2_data", 32'(data), 32'd5);
        step(1'b0, 24'h000005, 1'b1);
        check_eq("pulse_end", 32'(valid), 32'd0);

        // All lanes change together: eight back-to-back transfers in index order
        step(1'b1, 24'h0, 1'b1);
        step(1'b0, 24'h0, 1'b1);
        step(1'b0, 24'hFFFFFF, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 24'hFFFFFF, 1'b1);
            check_eq("all_valid", 32'(valid), 32'd1);
            check_eq("all_sel", 32'(sel), 32'(k));
            check_eq("all_data", 32'(data), 32'd7);
        end
        step(1'b0, 24'hFFFFFF, 1'b1);
        check_eq("all_done", 32'(valid), 32'd0);

        // Stall: lane 2 changes again while its first update is held
        step(1'b1, 24'h0, 1'b0);
        step(1'b0, 24'h0, 1'b0);
        step(1'b0, 24'h0000C0, 1'b0);
        step(1'b0, 24'h0000C0, 1'b0);
        check_eq("stall_sel", 32'(sel), 32'd2);
        check_eq("stall_data", 32'(data), 32'd3);
        step(1'b0, 24'h000140, 1'b0);
        step(1'b0, 24'h000140, 1'b0);
        check_eq("stall_hold_v", 32'(valid), 32'd1);
        check_eq("stall_hold_d", 32'(data), 32'd3);
        step(1'b0, 24'h000140, 1'b1);
        check_eq("stall_new_v", 32'(valid), 32'd1);
        check_eq("stall_new_s", 32'(sel), 32'd2);
        check_eq("stall_new_d", 32'(data), 32'd5);
        step(1'b0, 24'h000140, 1'b1);
        check_eq("stall_done", 32'(valid), 32'd0);

`ifdef SEL_SCHED_DROP_CNT_EN
        // Lane 1 toggles with the sink stalled: overwrite counter saturates
        step(1'b1, 24'h0, 1'b0);
        step(1'b0, 24'h0, 1'b0);
        for (int t = 0; t < 300; t++) begin
            step(1'b0, (t % 2 == 0) ? 24'h000008 : 24'h000000, 1'b0);
        end
        check_eq("drop_sat", 32'(drop_cnt), 32'd255);
        check_eq("drop_valid", 32'(valid), 32'd1);
`endif

        // Reset mid-handshake discards everything; lane 0 wins first afterwards
        step(1'b1, 24'h0, 1'b1);
        step(1'b0, 24'h0, 1'b1);
        step(1'b0, 24'hFFFFFF, 1'b0);
        step(1'b0, 24'hFFFFFF, 1'b0);
        check_eq("mid_valid", 32'(valid), 32'd1);
        step(1'b1, 24'hFFFFFF, 1'b0);
        check_eq("mid_rst_valid", 32'(valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 24'hFFFFFF, 1'b1);
            check_eq("no_replay", 32'(valid), 32'd0);
        end
        step(1'b0, 24'hE3FFF8, 1'b1);
        step(1'b0, 24'hE3FFF8, 1'b1);
        check_eq("post_rst_sel0", 32'(sel), 32'd0);
        check_eq("post_rst_v0", 32'(valid), 32'd1);
        step(1'b0, 24'hE3FFF8, 1'b1);
        check_eq("post_rst_sel6", 32'(sel), 32'd6);
        step(1'b0, 24'hE3FFF8, 1'b1);
        check_eq("post_rst_done", 32'(valid), 32'd0);

        // Random traffic against the model
        a = 24'hE3FFF8;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                a = a ^ (24'($urandom) & 24'($urandom) & 24'($urandom));
            end
            step(($urandom_range(0, 99) == 0), a, ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sel_scheduler.md
SEL_SCHEDULER -- requirements
Module: sel_scheduler

Interface
REQ-001 SHALL have parameter LANES, default 8, number of lanes the 24-bit input word is split into.
REQ-002 SHALL have parameter LANE_W, default 3, bits per lane; LANES*LANE_W is the input width (24).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port A, input, LANES*LANE_W, monitored data word; lane i is A[i*LANE_W +: LANE_W].
REQ-006 SHALL have port ready, input, 1, downstream accepts the current output.
REQ-007 SHALL have port valid, output, 1, sel/data hold an unsent lane update.
REQ-008 SHALL have port sel, output, $clog2(LANES) (3), index of the lane being presented.
REQ-009 SHALL have port data, output, LANE_W, newest captured value of lane sel.
REQ-010 SHALL have port drop_cnt, output, 8, overwrite counter (present only with SEL_SCHED_DROP_CNT_EN).

Function
REQ-011 SHALL register A into a_prev every cycle; lane i has changed when its lane of A differs from its lane of a_prev.
REQ-012 SHALL, on the first cycle after reset, load a_prev from A without flagging any change.
REQ-013 SHALL, on a lane change, set pending[i] and write the new lane value into hold[i] at the same edge.
REQ-014 SHALL, while valid=0 or (valid=1 and ready=1), load the output register from the next pending lane, chosen round-robin from last granted index +1, wrapping LANES-1 to 0, and clear that lane's pending bit at the same edge.
REQ-015 SHALL, when a lane changes in the same cycle it is granted, keep pending set; set wins over clear.
REQ-016 SHALL hold valid, sel and data stable while valid=1 and ready=0; newer changes go only to hold[] and pending[].
REQ-017 SHALL deassert valid after a transfer when no lane is pending; throughput SHALL be one transfer per cycle with ready held high.
REQ-018 SHALL have a latency of 2 cycles from the edge at which A first differs to valid=1, when idle and no other lane is pending.
REQ-019 SHALL, when all LANES change in one cycle, present all of them in index order starting after the last grant, with no loss.
REQ-020 SHALL ignore ready while valid=0.

Reset
REQ-021 SHALL, while rst=1, drive valid=0, sel=0, data=0 and drop_cnt=0, clear pending[] and hold[], and set the last-grant pointer to LANES-1 so that lane 0 has first priority.
REQ-022 SHALL, when reset is asserted mid-handshake, discard the presented and pending updates; there is no replay after reset.

Configuration
REQ-023 SHALL, when SEL_SCHED_DROP_CNT_EN is defined, increment drop_cnt by 1, saturating at 255, each cycle a change hits a lane whose pending bit is already set (an overwrite).
REQ-024 SHALL, without SEL_SCHED_DROP_CNT_EN, omit the drop_cnt port and its counter; all other behaviour SHALL be identical.

Structure
REQ-025 SHALL take LANES, LANE_W and SEL_W from shared package sel_sched_pkg, together with the lane-slice helper function.
REQ-026 SHALL implement the round-robin selection in sub-module rr_arbiter, with ports req[LANES], ptr and grant index/valid, and no internal state.

Verification
REQ-027 SHALL cover: reset, then A=0x000000 held constant -> valid stays 0 for 20 cycles.
REQ-028 SHALL cover: A 0x000000 -> 0x000005 with ready=1 -> valid=1 two cycles later with sel=0, data=5, for exactly one cycle.
REQ-029 SHALL cover: A 0x000000 -> 0xFFFFFF with ready=1 -> eight consecutive transfers with sel=0..7 and data=7 each, then valid=0.
REQ-030 SHALL cover: lane 2 changes while the lane-2 update is stalled (ready=0) -> the old data stays on the output; after ready=1 the new value follows as a second transfer.
REQ-031 SHALL cover, with SEL_SCHED_DROP_CNT_EN: lane 1 toggles 300 times with ready=0 -> drop_cnt=255 (saturated) and valid held.
REQ-032 SHALL cover: rst asserted while valid=1 -> next cycle valid=0, pending cleared, and lane 0 served first afterwards.
